button_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the SoC core's interrupt and GPIO inputs.
- Takes raw asynchronous board inputs (pushbuttons, switches) and, per channel, does three things: 2-flop synchronization, counter-based debouncing, and rise/fall edge-pulse generation.
- Each channel also has a sticky interrupt-pending flag with per-channel acknowledge, so short button presses are never lost by the core's irq lines.

---
 rtl/button_conditioner.sv | 75 +++++++
 tb/tb_button_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-channel input conditioning: 2-flop synchronizer, counter debouncer,
// registered rise/fall pulses and a sticky, acknowledgeable interrupt flag.
module button_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] irq_pending,
  input  logic [WIDTH-1:0] irq_ack
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] raw_norm;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Normalise polarity before synchronizing so level_out=1 always means pressed.
  assign raw_norm = ACTIVE_LOW ? ~raw_in : raw_in;

  // NOTE: default every always_comb output before the loop so no latch is inferred.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != level_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // An accepted change adopts the synchronized level, so its direction is sync2.
  assign rise_evt = accept & sync2;
  assign fall_evt = accept & ~sync2;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1       <= '0;
      sync2       <= '0;
      level_out   <= '0;
      rise_pulse  <= '0;
      fall_pulse  <= '0;
      irq_pending <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= raw_norm;
      sync2       <= sync1;
      level_out   <= level_out ^ accept;
      rise_pulse  <= rise_evt;
      fall_pulse  <= fall_evt;
      // A new rise beats a coincident acknowledge so no press is lost.
      irq_pending <= rise_evt | (irq_pending & ~irq_ack);
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == level_out[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse
// events, a negedge monitor pops and compares them as pulses appear.
module tb_button_conditioner;

  localparam int W   = 4;
  localparam int DC  = 8;
  localparam int LAT = DC + 2;

  typedef struct {
    int         edge_n;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
    logic [3:0] pend;
    string      name;
  } evt_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] raw_in;
  logic [W-1:0] irq_ack;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] irq_pending;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  evt_t exp_q[$];

  button_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq_pending(irq_pending),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_evt(input int e, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] l, input logic [3:0] p, input string n);
    evt_t ev;
    ev.edge_n = e;
    ev.rise   = r;
    ev.fall   = f;
    ev.level  = l;
    ev.pend   = p;
    ev.name   = n;
    exp_q.push_back(ev);
  endtask

  task automatic check_all_zero(input string n);
    check({n, "_level"}, 32'(level_out), 32'h0);
    check({n, "_rise"}, 32'(rise_pulse), 32'h0);
    check({n, "_fall"}, 32'(fall_pulse), 32'h0);
    check({n, "_pend"}, 32'(irq_pending), 32'h0);
  endtask

  task automatic ack(input logic [3:0] m);
    irq_ack = m;
    tick(1);
    irq_ack = '0;
  endtask

  // Monitor: every cycle that shows a pulse must match the oldest queued event.
  always @(negedge clk) begin
    evt_t ev;
    if ((rise_pulse | fall_pulse) != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got rise=0x%0h fall=0x%0h expected none (edge %0d)",
                 rise_pulse, fall_pulse, cyc);
      end else begin
        ev = exp_q.pop_front();
        check({ev.name, "_edge"}, 32'(cyc), 32'(ev.edge_n));
        check({ev.name, "_rise"}, 32'(rise_pulse), 32'(ev.rise));
        check({ev.name, "_fall"}, 32'(fall_pulse), 32'(ev.fall));
        check({ev.name, "_level"}, 32'(level_out), 32'(ev.level));
        check({ev.name, "_pend"}, 32'(irq_pending), 32'(ev.pend));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn  = 1'b0;
    raw_in  = 4'hF;
    irq_ack = 4'h0;

    // 1. Reset with all inputs high, then debounce to all-pressed.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_all_zero("t1_in_reset");
    end
    resetn = 1'b1;
    expect_evt(cyc + LAT, 4'hF, 4'h0, 4'hF, 4'hF, "t1_rise");
    tick(9);
    check("t1_level_before", 32'(level_out), 32'h0);
    tick(3);
    check("t1_level_after", 32'(level_out), 32'hF);
    check("t1_pend_after", 32'(irq_pending), 32'hF);
    ack(4'hF);
    check("t1_ack_all", 32'(irq_pending), 32'h0);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'hF, 4'h0, 4'h0, "t1_fall");
    tick(14);

    // 2. Clean press and release on ch1; fall leaves the pending flag alone.
    raw_in = 4'h2;
    expect_evt(cyc + LAT, 4'h2, 4'h0, 4'h2, 4'h2, "t2_rise");
    tick(20);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'h2, 4'h0, 4'h2, "t2_fall");
    tick(14);
    check("t2_pend_kept", 32'(irq_pending), 32'h2);
    ack(4'h2);
    check("t2_ack", 32'(irq_pending), 32'h0);

    // 3. Bounce on ch2: 3-cycle toggles for 30 cycles, then hold high.
    for (int s = 0; s < 10; s++) begin
      raw_in = (s % 2 == 0) ? 4'h4 : 4'h0;
      tick(3);
    end
    raw_in = 4'h4;
    expect_evt(cyc + LAT, 4'h4, 4'h0, 4'h4, 4'h4, "t3_rise");
    tick(9);
    check("t3_level_before", 32'(level_out), 32'h0);
    tick(5);
    check("t3_level_after", 32'(level_out), 32'h4);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'h4, 4'h0, 4'h4, "t3_fall");
    tick(14);
    ack(4'h4);

    // 4. Threshold on ch0: 7-cycle glitch rejected, 8-cycle glitch accepted.
    raw_in = 4'h1;
    tick(7);
    raw_in = 4'h0;
    tick(14);
    check("t4_glitch7_level", 32'(level_out), 32'h0);
    check("t4_glitch7_pend", 32'(irq_pending), 32'h0);
    raw_in = 4'h1;
    expect_evt(cyc + LAT, 4'h1, 4'h0, 4'h1, 4'h1, "t4_g8_rise");
    tick(8);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'h1, 4'h0, 4'h1, "t4_g8_fall");
    tick(14);
    check("t4_pend", 32'(irq_pending), 32'h1);
    ack(4'h1);

    // 5. Acknowledge on ch3: plain clear, then ack coincident with a new rise.
    raw_in = 4'h8;
    expect_evt(cyc + LAT, 4'h8, 4'h0, 4'h8, 4'h8, "t5_rise_a");
    tick(12);
    check("t5_pend_set", 32'(irq_pending), 32'h8);
    ack(4'h8);
    check("t5_ack_clear", 32'(irq_pending), 32'h0);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'h8, 4'h0, 4'h0, "t5_fall_a");
    tick(14);
    raw_in = 4'h8;
    expect_evt(cyc + LAT, 4'h8, 4'h0, 4'h8, 4'h8, "t5_rise_ack");
    tick(9);
    ack(4'h8);
    tick(1);
    check("t5_set_wins", 32'(irq_pending), 32'h8);
    raw_in = 4'h0;
    expect_evt(cyc + LAT, 4'h0, 4'h8, 4'h0, 4'h8, "t5_fall_b");
    tick(14);
    ack(4'h8);
    check("t5_final_clear", 32'(irq_pending), 32'h0);

    // 6. Reset mid-count on ch1 discards the count; debounce restarts after release.
    raw_in = 4'h2;
    tick(7);
    resetn = 1'b0;
    tick(1);
    check_all_zero("t6_in_reset_a");
    tick(1);
    check_all_zero("t6_in_reset_b");
    resetn = 1'b1;
    expect_evt(cyc + LAT, 4'h2, 4'h0, 4'h2, 4'h2, "t6_rise");
    tick(9);
    check("t6_level_before", 32'(level_out), 32'h0);
    tick(5);
    check("t6_level_after", 32'(level_out), 32'h2);
    check("t6_pend", 32'(irq_pending), 32'h2);
    tick(4);

    check("events_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
